// File: rtl/score_frame_tx_if.sv
// ---------------------------------------------------------------------------
// score_frame_tx_if
// Purpose : bundles the frame-request side and the UART byte-transmit side
//           of score_frame_tx into one interface.
// Signals :
//   send      frame request (level or pulse)
//   board_ID  2-bit board identifier
//   points    24-bit BCD score {d5..d0}
//   busy      frame in progress
//   done      one-cycle pulse after the last byte of a frame completes
//   err       sticky ack-timeout flag
//   tx_data   byte presented to the UART
//   tx_start  one-cycle load strobe to the UART
//   tx_busy   UART transmitter busy
// Modports:
//   master  frame sender (score_frame_tx)
//   slave   surrounding logic: requester and UART
// ---------------------------------------------------------------------------
interface score_frame_tx_if;
  logic        send;
  logic [1:0]  board_ID;
  logic [23:0] points;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;

  modport master (
    input  send, board_ID, points, tx_busy,
    output tx_data, tx_start, busy, done, err
  );

  modport slave (
    output send, board_ID, points, tx_busy,
    input  tx_data, tx_start, busy, done, err
  );
endinterface

// File: rtl/score_frame_tx.sv
// ---------------------------------------------------------------------------
// score_frame_tx
// Purpose : serialises the board ID and the 6-digit BCD score into a framed
//           byte packet for a UART byte transmitter. Each byte is handed over
//           with a tx_start / tx_busy handshake, and an idle gap follows every
//           byte. ID and score are snapshotted when the frame is accepted, so
//           they may change freely while the frame is being sent. One further
//           request arriving during a frame is queued.
//
// Frame   : B0=SOF_BYTE, B1={6'b0,ID}, B2=points[23:16], B3=points[15:8],
//           B4=points[7:0], B5=B1^B2^B3^B4 (checksum build only)
//
// Build option:
//   SCORE_FRAME_CHECKSUM_EN  defined     -> 6-byte frame including checksum B5
//                            not defined -> 5-byte frame, no checksum logic
//
// Parameters:
//   SOF_BYTE     start-of-frame byte
//   GAP_CYCLES   idle cycles after each completed byte (0 = no gap)
//   ACK_TIMEOUT  cycles from tx_start allowed for tx_busy to rise
//
// Ports:
//   pclk  in  clock, rising edge
//   rst   in  asynchronous reset, active low
//   bus   score_frame_tx_if.master (request side + UART side)
//
// State table:
//   S_IDLE     | no frame; accept on send or a queued request
//   S_WAIT_RDY | wait for the UART to become idle
//   S_STROBE   | tx_start high for one cycle with the current byte
//   S_WAIT_ACK | wait for tx_busy to rise, bounded by the ack timer
//   S_WAIT_TXD | wait for tx_busy to fall (byte shifted out)
//   S_GAP      | inter-byte idle time
//   S_DONE     | one-cycle done pulse
// ---------------------------------------------------------------------------
module score_frame_tx #(
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic             pclk,
  input  logic             rst,
  score_frame_tx_if.master bus
);

`ifdef SCORE_FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  // The ack timer starts in the cycle after the strobe and times out in the
  // last WAIT_ACK cycle, so that err appears ACK_TIMEOUT cycles after tx_start.
  localparam logic [15:0] ACK_LOAD = (ACK_TIMEOUT >= 2) ? 16'(ACK_TIMEOUT - 2) : 16'd0;
  // GAP spends exactly GAP_CYCLES cycles, counting down to zero inclusive.
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES >= 1) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam bit          GAP_EN   = (GAP_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_STROBE   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_TXD = 3'd4,
    S_GAP      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        accept;
  logic        byte_end;
  logic [1:0]  id_q;
  logic [23:0] pts_q;
  logic [7:0]  cur_byte;

  // Byte selected by the current index, built from the snapshot only.
  always_comb begin
    cur_byte = 8'h00;
    unique case (idx_q)
      3'd0: cur_byte = SOF_BYTE;
      3'd1: cur_byte = {6'b0, id_q};
      3'd2: cur_byte = pts_q[23:16];
      3'd3: cur_byte = pts_q[15:8];
      3'd4: cur_byte = pts_q[7:0];
`ifdef SCORE_FRAME_CHECKSUM_EN
      3'd5: cur_byte = {6'b0, id_q} ^ pts_q[23:16] ^ pts_q[15:8] ^ pts_q[7:0];
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    pend_d    = pend_q;
    accept    = 1'b0;
    byte_end  = 1'b0;

    // Requests during a frame (DONE included) merge into one queued frame.
    if ((state_q != S_IDLE) && bus.send) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.send || pend_q) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (!bus.tx_busy) begin
          tx_data_d = cur_byte;
          state_d   = S_STROBE;
        end
      end
      S_STROBE: begin
        tmr_d   = ACK_LOAD;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_TXD;
        end else if (tmr_q == 16'd0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_WAIT_TXD: begin
        if (!bus.tx_busy) begin
          if (GAP_EN) begin
            tmr_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            byte_end = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tmr_q == 16'd0) begin
          byte_end = 1'b1;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Index stops at the last byte; it never wraps.
    if (byte_end) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = S_WAIT_RDY;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      tmr_q     <= 16'd0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      id_q  <= 2'd0;
      pts_q <= 24'd0;
    end else if (accept) begin
      id_q  <= bus.board_ID;
      pts_q <= bus.points;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state_q == S_STROBE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_score_frame_tx.sv
module tb_score_frame_tx;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  score_frame_tx_if sfif ();

  score_frame_tx #(
    .SOF_BYTE    (8'hA5),
    .GAP_CYCLES  (16),
    .ACK_TIMEOUT (8)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (sfif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int start_cnt = 0;
  int done_cnt  = 0;

  // UART model: 0 = normal, 1 = tx_busy stuck low, 2 = tx_busy toggling
  int   uart_mode = 0;
  bit   rand_lat  = 0;
  bit   armed     = 0;
  int   ack_cnt   = 0;
  int   busy_cnt  = 0;
  int   busy_len  = 10;
  int   ack_dly   = 1;
  logic [7:0] cur_b = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (sfif.tx_start) begin
      start_cnt++;
      rx_q.push_back(sfif.tx_data);
    end
    if (sfif.done) begin
      done_cnt++;
      check("busy_during_done", 32'(sfif.busy), 32'd1);
    end
    if (uart_mode == 2) begin
      sfif.tx_busy = ~sfif.tx_busy;
    end else if (!rst || uart_mode == 1) begin
      sfif.tx_busy = 1'b0;
      armed        = 0;
      busy_cnt     = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          sfif.tx_busy = 1'b0;
          check("tx_data_stable", 32'(sfif.tx_data), 32'(cur_b));
        end
      end else if (armed) begin
        if (ack_cnt == 0) begin
          sfif.tx_busy = 1'b1;
          busy_cnt     = busy_len;
          armed        = 0;
        end else begin
          ack_cnt--;
        end
      end
      if (sfif.tx_start) begin
        cur_b = sfif.tx_data;
        if (rand_lat) begin
          ack_dly  = int'($urandom_range(0, 3));
          busy_len = int'($urandom_range(1, 12));
        end else begin
          ack_dly  = 1;
          busy_len = 10;
        end
        if (ack_dly == 0) begin
          sfif.tx_busy = 1'b1;
          busy_cnt     = busy_len;
        end else begin
          armed   = 1;
          ack_cnt = ack_dly - 1;
        end
      end
    end
  end

  // Reference frame from the byte-order rules; checksum is the XOR of B1..B4.
  task automatic add_expected(input logic [1:0] id, input logic [23:0] p);
    logic [7:0] body[4];
    logic [7:0] cs;
    body[0] = {6'b0, id};
    body[1] = p[23:16];
    body[2] = p[15:8];
    body[3] = p[7:0];
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(body[k]);
      cs = cs ^ body[k];
    end
`ifdef SCORE_FRAME_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic cmp_stream(input string name);
    check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check($sformatf("%s_byte%0d", name, k), 32'(rx_q[k]), 32'(exp_q[k]));
  endtask

  task automatic wait_done(input int target, input string name);
    int t;
    t = 0;
    while (done_cnt < target && t < 5000) begin
      @(posedge pclk);
      t++;
    end
    check({name, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic pulse_send();
    @(posedge pclk); #1;
    sfif.send = 1'b1;
    @(posedge pclk); #1;
    sfif.send = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] id, input logic [23:0] p, input bit scramble,
                           input string name);
    int d0;
    rx_q.delete();
    exp_q.delete();
    add_expected(id, p);
    d0 = done_cnt;
    sfif.board_ID = id;
    sfif.points   = p;
    pulse_send();
    check({name, "_accept"}, 32'({sfif.busy, sfif.tx_start, sfif.err}), 32'b100);
    if (scramble) begin
      sfif.board_ID = 2'($urandom);
      sfif.points   = 24'($urandom);
    end
    @(posedge pclk); #1;
    check({name, "_strobe_latency"}, 32'(sfif.tx_start), 32'd1);
    wait_done(d0 + 1, name);
    repeat (5) @(posedge pclk);
    #1;
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_err_busy"}, 32'({sfif.err, sfif.busy}), 32'b00);
    cmp_stream(name);
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [23:0] pts;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0, s0, t;
    logic [23:0] rp;
    logic [1:0]  rid;

    vecs[0] = '{2'd2, 24'h012345, 8'h65};
    vecs[1] = '{2'd3, 24'h999999, 8'h9A};
    vecs[2] = '{2'd0, 24'h000000, 8'h00};
    vecs[3] = '{2'd1, 24'h123456, 8'h71};
    vecs[4] = '{2'd2, 24'h999999, 8'h9B};
    vecs[5] = '{2'd1, 24'h987654, 8'hBB};

    sfif.send     = 1'b1;
    sfif.board_ID = 2'd2;
    sfif.points   = 24'h012345;
    sfif.tx_busy  = 1'b0;

    // Reset held with send high and tx_busy toggling
    rst       = 1'b0;
    uart_mode = 2;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      check($sformatf("reset_outputs%0d", i),
            32'({sfif.tx_data, sfif.tx_start, sfif.busy, sfif.done, sfif.err}), 32'd0);
    end
    @(posedge pclk); #1;
    sfif.send = 1'b0;
    uart_mode = 0;
    @(negedge pclk);
    @(posedge pclk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check($sformatf("post_reset_idle%0d", i), 32'(sfif.busy), 32'd0);
    end

    // Table of known frames, hand-computed checksums
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].id, vecs[i].pts, 1'b0, $sformatf("vec%0d", i));
`ifdef SCORE_FRAME_CHECKSUM_EN
      check($sformatf("vec%0d_csum", i), 32'((rx_q.size() > 5) ? rx_q[5] : 8'hxx), 32'(vecs[i].csum));
`endif
    end

    // Snapshot and merged pending requests
    rx_q.delete();
    exp_q.delete();
    add_expected(2'd2, 24'h012345);
    add_expected(2'd2, 24'h999999);
    d0 = done_cnt;
    sfif.board_ID = 2'd2;
    sfif.points   = 24'h012345;
    pulse_send();
    sfif.points = 24'h999999;
    repeat (20) @(posedge pclk);
    pulse_send();
    repeat (30) @(posedge pclk);
    pulse_send();
    wait_done(d0 + 2, "pending");
    repeat (80) @(posedge pclk);
    #1;
    check("pending_done_count", 32'(done_cnt - d0), 32'd2);
    check("pending_idle", 32'(sfif.busy), 32'd0);
    cmp_stream("pending");

    // Ack timeout with tx_busy stuck low
    uart_mode = 1;
    s0 = start_cnt;
    d0 = done_cnt;
    pulse_send();
    @(posedge pclk); #1;
    check("timeout_strobe", 32'(sfif.tx_start), 32'd1);
    repeat (7) @(posedge pclk);
    #1;
    check("timeout_err_before", 32'({sfif.err, sfif.busy}), 32'b01);
    @(posedge pclk); #1;
    check("timeout_err_set", 32'({sfif.err, sfif.busy}), 32'b10);
    repeat (40) @(posedge pclk);
    #1;
    check("timeout_one_start", 32'(start_cnt - s0), 32'd1);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check("timeout_err_sticky", 32'(sfif.err), 32'd1);
    uart_mode = 0;
    run_frame(2'd1, 24'h123456, 1'b0, "timeout_recover");

    // Reset in the middle of the third byte
    rx_q.delete();
    s0 = start_cnt;
    sfif.board_ID = 2'd3;
    sfif.points   = 24'h999999;
    pulse_send();
    t = 0;
    while (start_cnt - s0 < 3 && t < 2000) begin
      @(negedge pclk);
      t++;
    end
    check("midreset_reached_byte3", 32'(start_cnt - s0 >= 3), 32'd1);
    @(posedge pclk); #2;
    rst = 1'b0;
    #1;
    check("midreset_outputs",
          32'({sfif.tx_data, sfif.tx_start, sfif.busy, sfif.done, sfif.err}), 32'd0);
    repeat (3) @(posedge pclk);
    #1;
    rx_q.delete();
    exp_q.delete();
    add_expected(2'd3, 24'h999999);
    d0 = done_cnt;
    rst       = 1'b1;
    sfif.send = 1'b1;
    @(posedge pclk); #1;
    sfif.send = 1'b0;
    wait_done(d0 + 1, "midreset");
    repeat (5) @(posedge pclk);
    #1;
    check("midreset_done_count", 32'(done_cnt - d0), 32'd1);
    cmp_stream("midreset");

    // Randomized frames, UART latency and busy length, and mid-frame input churn
    rand_lat = 1;
    for (int i = 0; i < 8; i++) begin
      rid = 2'($urandom_range(0, 3));
      rp  = 24'd0;
      for (int k = 0; k < 6; k++)
        rp = {rp[19:0], 4'($urandom_range(0, 9))};
      run_frame(rid, rp, 1'b1, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
